// File: rtl/gate_vector_sequencer_if.sv
// Signal bundle between the gate-vector sequencer and its surroundings:
// run control, stimulus to the gates block, its responses and the result report.
interface gate_vector_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic             t0;
  logic             t1;
  logic             t2;
  logic             a;
  logic             b;
  logic             c;
  logic [2:0]       vec_idx;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [2:0]       first_err_vec;
  logic             first_err_valid;

  modport master (
    input  start, abort, t0, t1, t2,
    output a, b, c, vec_idx, busy, done, pass,
           err_count, first_err_vec, first_err_valid
  );

  modport slave (
    output start, abort, t0, t1, t2,
    input  a, b, c, vec_idx, busy, done, pass,
           err_count, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/gate_vector_sequencer.sv
// Steps a,b,c through all eight combinations, holds each for HOLD_CYCLES,
// and checks the returned AND/OR/NOT outputs against the truth table.
module gate_vector_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input logic                     clk,
  input logic                     rst,
  gate_vector_sequencer_if.master bus_io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [7:0]       hold_q, hold_d;
  logic [2:0]       abc_q, abc_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [2:0]       fvec_q, fvec_d;
  logic             fvalid_q, fvalid_d;

  logic             sample;
  logic             mismatch;
  logic             busy_o;
  logic             done_o;

  // An abort on the sampling edge discards that vector's comparison.
  assign sample   = (state_q == S_RUN) && (hold_q == HOLD_LAST) && !bus_io.abort;
  assign mismatch = (bus_io.t0 != (abc_q[2] & abc_q[1])) ||
                    (bus_io.t1 != (abc_q[2] | abc_q[1])) ||
                    (bus_io.t2 != ~abc_q[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus_io.abort) begin
          state_d = S_IDLE;
        end else if (bus_io.start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus_io.abort) begin
          state_d = S_IDLE;
        end else if (sample && (vec_q == 3'd7)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == S_RUN);
    done_o = (state_q == S_DONE);
  end

  always_comb begin
    vec_d    = vec_q;
    hold_d   = hold_q;
    err_d    = err_q;
    fvec_d   = fvec_q;
    fvalid_d = fvalid_q;
    case (state_q)
      S_RUN: begin
        if (bus_io.abort) begin
          vec_d  = 3'd0;
          hold_d = 8'd0;
        end else if (sample) begin
          hold_d = 8'd0;
          if (vec_q != 3'd7) begin
            vec_d = vec_q + 3'd1;
          end
          if (mismatch) begin
            if (err_q != {CNT_W{1'b1}}) begin
              err_d = err_q + 1'b1;
            end
            if (!fvalid_q) begin
              fvec_d   = vec_q;
              fvalid_d = 1'b1;
            end
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        if (bus_io.abort) begin
          vec_d  = 3'd0;
          hold_d = 8'd0;
        end else if (bus_io.start) begin
          vec_d    = 3'd0;
          hold_d   = 8'd0;
          err_d    = '0;
          fvec_d   = 3'd0;
          fvalid_d = 1'b0;
        end
      end
    endcase
    // Stimulus tracks the vector index only while running; zero elsewhere.
    abc_d = (state_d == S_RUN) ? vec_d : 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q    <= 3'd0;
      hold_q   <= 8'd0;
      abc_q    <= 3'd0;
      err_q    <= '0;
      fvec_q   <= 3'd0;
      fvalid_q <= 1'b0;
    end else begin
      vec_q    <= vec_d;
      hold_q   <= hold_d;
      abc_q    <= abc_d;
      err_q    <= err_d;
      fvec_q   <= fvec_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign bus_io.a               = abc_q[2];
  assign bus_io.b               = abc_q[1];
  assign bus_io.c               = abc_q[0];
  assign bus_io.vec_idx         = vec_q;
  assign bus_io.busy            = busy_o;
  assign bus_io.done            = done_o;
  assign bus_io.pass            = done_o && (err_q == '0);
  assign bus_io.err_count       = err_q;
  assign bus_io.first_err_vec   = fvec_q;
  assign bus_io.first_err_valid = fvalid_q;

endmodule
